// File: rtl/data_cache_controller.sv
// data_cache_controller
// Direct-mapped, write-through data cache for the MEM stage. One 32-bit word
// per line. Loads that hit return in the same cycle. Load misses and all
// stores go to main memory over a single-outstanding request/ready handshake.
// Define DCACHE_STATS_EN to add the readHitCount / readMissCount outputs.
module data_cache_controller #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] readDataTwo,
  output logic        hit,
  output logic [31:0] readData,
  output logic [31:0] memAddress,
  output logic        memReadReq,
  output logic        memWriteReq,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  input  logic        memReady
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] readHitCount,
  output logic [31:0] readMissCount
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE_MEM = 2'd2,
    RESPOND   = 2'd3
  } stateType;

  stateType state;
  stateType nextState;

  // Line storage: valid bits are reset, tag/data arrays are not
  logic [LINES-1:0]    validBits;
  logic [TAG_BITS-1:0] tagArray  [LINES];
  logic [31:0]         dataArray [LINES];
  logic [31:0]         fillData;

  logic [INDEX_BITS-1:0] reqIndex;
  logic [TAG_BITS-1:0]   reqTag;
  logic [INDEX_BITS-1:0] fillIndex;
  logic [TAG_BITS-1:0]   fillTag;
  logic                  isStore;
  logic                  isLoad;
  logic                  lineHit;
  logic                  readHit;
  logic                  readMiss;
  logic                  storeAlloc;
  logic                  missFill;
  logic                  unusedAddrBits;

  // Byte offset is irrelevant for word-sized lines
  assign unusedAddrBits = ^ALUResult[1:0];

  assign reqIndex  = ALUResult[INDEX_BITS+1:2];
  assign reqTag    = ALUResult[31:INDEX_BITS+2];
  // The fill targets the address latched at miss time, not the live input
  assign fillIndex = memAddress[INDEX_BITS+1:2];
  assign fillTag   = memAddress[31:INDEX_BITS+2];

  // A store wins when both requests are asserted
  assign isStore = memWrite;
  assign isLoad  = memRead & ~memWrite;

  assign lineHit    = validBits[reqIndex] && (tagArray[reqIndex] == reqTag);
  assign readHit    = (state == IDLE) && isLoad && lineHit;
  assign readMiss   = (state == IDLE) && isLoad && !lineHit;
  assign storeAlloc = (state == IDLE) && isStore;
  assign missFill   = (state == READ_MISS) && memReady;

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state, stall and read-data selection
  always_comb begin
    nextState = state;
    hit       = 1'b1;
    readData  = fillData;
    case (state)
      IDLE: begin
        if (isStore) begin
          hit       = 1'b0;
          nextState = WRITE_MEM;
        end else if (isLoad) begin
          if (lineHit) begin
            readData = dataArray[reqIndex];
          end else begin
            hit       = 1'b0;
            nextState = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        hit = 1'b0;
        if (memReady) begin
          nextState = RESPOND;
        end
      end
      WRITE_MEM: begin
        hit = 1'b0;
        if (memReady) begin
          nextState = RESPOND;
        end
      end
      RESPOND: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Main-memory request registers and captured fill word
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      memAddress   <= '0;
      memReadReq   <= 1'b0;
      memWriteReq  <= 1'b0;
      memWriteData <= '0;
      fillData     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (isStore) begin
            memAddress   <= {ALUResult[31:2], 2'b00};
            memWriteData <= readDataTwo;
            memWriteReq  <= 1'b1;
          end else if (readMiss) begin
            memAddress <= {ALUResult[31:2], 2'b00};
            memReadReq <= 1'b1;
          end
        end
        READ_MISS: begin
          if (memReady) begin
            memReadReq <= 1'b0;
            fillData   <= memReadData;
          end
        end
        WRITE_MEM: begin
          if (memReady) begin
            memWriteReq <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Valid bits: set on store allocation or miss fill, cleared only by reset
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      validBits <= '0;
    end else if (storeAlloc) begin
      validBits[reqIndex] <= 1'b1;
    end else if (missFill) begin
      validBits[fillIndex] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set
  always_ff @(posedge clock) begin
    if (resetN && storeAlloc) begin
      tagArray[reqIndex]  <= reqTag;
      dataArray[reqIndex] <= readDataTwo;
    end else if (resetN && missFill) begin
      tagArray[fillIndex]  <= fillTag;
      dataArray[fillIndex] <= memReadData;
    end
  end

`ifdef DCACHE_STATS_EN
  // Wrapping read hit/miss event counters
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      readHitCount  <= '0;
      readMissCount <= '0;
    end else begin
      if (readHit) begin
        readHitCount <= readHitCount + 32'd1;
      end
      if (readMiss) begin
        readMissCount <= readMissCount + 32'd1;
      end
    end
  end
`else
  // Hit indication is only consumed by the statistics counters
  logic unusedReadHit;
  assign unusedReadHit = readHit;
`endif

endmodule
